// File: rtl/gamma_sequencer_if.sv
// Operand/result handshake and temporal-primitive wiring for gamma_sequencer.
// master = operand source / result sink / primitive, slave = sequencer.
interface gamma_sequencer_if #(
    parameter int VAL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [VAL_W-1:0] a_val;
    logic [VAL_W-1:0] b_val;
    logic             a_none;
    logic             b_none;
    logic             grst;
    logic             a;
    logic             b;
    logic             y;
    logic             res_valid;
    logic             res_ready;
    logic [VAL_W-1:0] res_time;
    logic             res_none;

    modport master (
        output in_valid, a_val, b_val, a_none, b_none, y, res_ready,
        input  in_ready, grst, a, b, res_valid, res_time, res_none
    );

    modport slave (
        input  in_valid, a_val, b_val, a_none, b_none, y, res_ready,
        output in_ready, grst, a, b, res_valid, res_time, res_none
    );
endinterface

// File: rtl/gamma_sequencer.sv
// Drives one gamma cycle of spike stimulus into a temporal primitive and reports first y=1 time.
// GAMMA_SEQ_EDGE_MODE_EN selects rising-edge encoding instead of pulse-width encoding.
module gamma_sequencer #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int VAL_W             = 4
) (
    input logic              aclk,
    input logic              rst,
    gamma_sequencer_if.slave bus
);
    localparam int KW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, GRST, RUN, REPORT} state_t;

    state_t           state, state_nx;
    logic [KW-1:0]    k, k_nx;
    logic [VAL_W-1:0] a_lat, b_lat;
    logic             a_none_lat, b_none_lat;
    logic             in_ready_q, grst_q, a_q, b_q, res_valid_q, res_none_q;
    logic [VAL_W-1:0] res_time_q;
    logic             a_nx, b_nx;
    logic             accept, done;

    function automatic logic fire(input logic [VAL_W-1:0] lat, input logic none,
                                  input logic [KW-1:0] kk);
        int unsigned t, s;
        t = 32'(kk);
        s = 32'(lat);
`ifdef GAMMA_SEQ_EDGE_MODE_EN
        return !none && (t >= s);
`else
        // k never passes GAMMA_CYCLE_WIDTH-1, so late pulses are clipped, not wrapped
        return !none && (t >= s) && (t < s + 32'(PULSE_WIDTH));
`endif
    endfunction

    assign accept = (state == IDLE) && in_ready_q && bus.in_valid;
    assign done   = (state == REPORT) && res_valid_q && bus.res_ready;

    always_comb begin
        state_nx = state;
        k_nx     = k;
        case (state)
            IDLE:    if (accept) state_nx = GRST;
            GRST: begin
                state_nx = RUN;
                k_nx     = '0;
            end
            RUN: begin
                if (k == KW'(GAMMA_CYCLE_WIDTH - 1)) state_nx = REPORT;
                else                                 k_nx     = k + 1'b1;
            end
            REPORT:  if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // stimulus is registered, so it is computed for the cycle being entered
        a_nx = (state_nx == RUN) && fire(a_lat, a_none_lat, k_nx);
        b_nx = (state_nx == RUN) && fire(b_lat, b_none_lat, k_nx);
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            a_lat       <= '0;
            b_lat       <= '0;
            a_none_lat  <= 1'b1;
            b_none_lat  <= 1'b1;
            in_ready_q  <= 1'b0;
            grst_q      <= 1'b1;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            res_valid_q <= 1'b0;
            res_time_q  <= '0;
            res_none_q  <= 1'b1;
        end else begin
            state       <= state_nx;
            k           <= k_nx;
            a_q         <= a_nx;
            b_q         <= b_nx;
            in_ready_q  <= (state_nx == IDLE);
            grst_q      <= (state_nx == GRST);
            res_valid_q <= (state_nx == REPORT);
            if (accept) begin
                a_lat      <= bus.a_val;
                b_lat      <= bus.b_val;
                a_none_lat <= bus.a_none;
                b_none_lat <= bus.b_none;
                k          <= '0;
                res_time_q <= '0;
                res_none_q <= 1'b1;
            end
            if (state == RUN && bus.y && res_none_q) begin
                res_time_q <= VAL_W'(k);
                res_none_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.grst      = grst_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_time  = res_time_q;
    assign bus.res_none  = res_none_q;
endmodule

// File: doc/gamma_sequencer.md
GAMMA_SEQUENCER -- requirements
Module: gamma_sequencer

Interface
REQ-001 Parameter GAMMA_CYCLE_WIDTH, default 16: aclk cycles per gamma cycle (RUN phase length).
REQ-002 Parameter PULSE_WIDTH, default 8: aclk cycles a spike stays high in pulse-width encoding.
REQ-003 Parameter VAL_W, default 4: operand width; requires 2^VAL_W <= GAMMA_CYCLE_WIDTH.
REQ-004 aclk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  sequencer accepts operands.
REQ-008 a_val, b_val  input  VAL_W  spike times in aclk cycles from RUN start.
REQ-009 a_none, b_none  input  1  channel never fires this gamma cycle.
REQ-010 grst  output  1  gamma reset to the downstream temporal primitive.
REQ-011 a, b  output  1  temporal stimulus driven to the primitive.
REQ-012 y  input  1  primitive result (e.g. not_equal output).
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_time  output  VAL_W  cycle index k of first y=1 during RUN.
REQ-016 res_none  output  1  y never observed high during RUN.

Function
REQ-017 FSM states: IDLE, GRST, RUN, REPORT; IDLE after reset.
REQ-018 IDLE: in_ready=1. in_valid=1 at an edge latches a_val/b_val/a_none/b_none and moves to GRST; otherwise stay in IDLE.
REQ-019 in_ready=0 in every state except IDLE; operands presented outside IDLE are ignored.
REQ-020 GRST: grst=1 for exactly one cycle; a=b=0; counter cleared to 0; next state RUN.
REQ-021 RUN: counter k runs 0..GAMMA_CYCLE_WIDTH-1, one step per cycle; after k=GAMMA_CYCLE_WIDTH-1, next state REPORT.
REQ-022 RUN: a is registered and high during cycle k iff a_none=0 and a_lat <= k < a_lat+PULSE_WIDTH. The pulse is clipped at k=GAMMA_CYCLE_WIDTH-1, not wrapped. Same rule for b.
REQ-023 RUN: y sampled every cycle. First k with y=1 is captured in res_time, and res_none is cleared. Later highs are ignored.
REQ-024 res_none initialised to 1 and res_time to 0 on GRST entry.
REQ-025 REPORT: a=b=0; res_valid=1; res_time/res_none held stable until res_valid&&res_ready at an edge, then return to IDLE.
REQ-026 Handshake latency: accept edge to first RUN cycle = 2 cycles. Total minimum occupancy = GAMMA_CYCLE_WIDTH+2 cycles plus REPORT wait.
REQ-027 No back-to-back overlap: a new operand pair is not accepted in the same edge as the result handshake (IDLE is at least one cycle).
REQ-028 a, b, grst, res_valid are all registered outputs; no combinational input-to-output paths except none.

Reset
REQ-029 rst=1 at an edge forces IDLE from any state, including mid-RUN and mid-REPORT; pending result discarded.
REQ-030 Outputs while rst is sampled high and the cycle after: grst=1, a=b=0, res_valid=0, res_time=0, res_none=1, in_ready=0. in_ready=1 from the following cycle.

Configuration
REQ-031 Macro GAMMA_SEQ_EDGE_MODE_EN.
 - Defined: rising-edge encoding. a stays high from k=a_lat through the end of RUN; PULSE_WIDTH is unused.
 - Undefined: pulse-width encoding per REQ-022.
 - All other behaviour is identical in both modes.

Verification
REQ-032 a_none=b_none=1, y tied to a^b -> a,b never high; res_none=1, res_time=0; grst high exactly 1 cycle before RUN.
REQ-033 a_val=2, b_val=4, y=a^b, default params:
 - a high k=2..9, b high k=4..11.
 - res_time=2, res_none=0, res_valid 16 cycles after first RUN cycle.
REQ-034 a_val=b_val=5, y=a^b -> res_none=1; a and b high together k=5..12.
REQ-035 a_val=12, b_none=1 -> a high k=12..15 only (clipped); with GAMMA_SEQ_EDGE_MODE_EN also k=12..15.
REQ-036 res_ready held 0 for 10 cycles in REPORT -> res_valid, res_time stable, in_ready=0 throughout; IDLE one cycle after handshake.
REQ-037 rst pulsed at RUN k=6 -> next cycle a=b=0, grst=1, res_valid=0; fresh operand pair afterwards completes normally.
